gng_rom_packer: RTL and testbench

GNG_ROM_PACKER -- requirements
Module: gng_rom_packer

---
 rtl/gng_rom_packer.sv | 257 +++++++++++++++++++++++++
 tb/tb_gng_rom_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gng_rom_packer.sv
// gng_rom_packer
//   Packs a byte-wide ROM download stream into 16-bit memory words.
//   Even-address bytes are parked as the low half of a word until the odd
//   partner arrives; unpaired halves are padded with zero. Packed words go
//   through a small FIFO to a req/ack memory write port. Bytes 0..3 are
//   compared against the 10 83 00 80 header, giving sig_ok at end of download.
// Ports
//   clk, rst              : clock (rising edge), async active-high reset
//   dl_active/dl_wr       : download window and one-cycle byte strobe
//   dl_addr/dl_data       : byte address and byte
//   dl_wait               : back-pressure to the download source
//   mem_req/mem_addr/
//   mem_data/mem_ack      : word write handshake (word address = byte addr >> 1)
//   done                  : one-cycle end-of-download pulse
//   sig_ok                : header matched on the last completed download
//   overflow              : sticky, a byte was dropped during this download
module gng_rom_packer #(
    parameter int          DEPTH = 4,
    parameter logic [24:0] LIMIT = 25'h0C0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic        done,
    output logic        sig_ok,
    output logic        overflow
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2'd2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    // Expected header byte for address 0..3
    function automatic logic [7:0] sig_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    sig_byte = 8'h10;
            2'd1:    sig_byte = 8'h83;
            2'd2:    sig_byte = 8'h00;
            default: sig_byte = 8'h80;
        endcase
    endfunction

    state_t        state_r, state_next_s;
    logic [23:0]   fifo_addr_r [DEPTH];
    logic [15:0]   fifo_data_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r, next_ptr_s;
    logic [CW-1:0] count_r;
    logic          pend_valid_r;
    logic [23:0]   pend_addr_r;
    logic [7:0]    pend_data_r;
    logic [3:0]    sig_flags_r;
    logic          sig_ok_r, overflow_r, done_r;
    logic          mem_req_r;
    logic [23:0]   mem_addr_r;
    logic [15:0]   mem_data_r;

    logic          want_push_s, push_s, reject_s, hold_s, clr_pend_s, drop_s;
    logic [23:0]   push_addr_s, word_addr_s;
    logic [15:0]   push_data_s;
    logic          pop_s, full_s, in_range_s, load_entry_s, flush_entry_s;

    assign word_addr_s   = dl_addr[24:1];
    assign in_range_s    = (dl_addr < LIMIT);
    assign full_s        = (count_r == FULL_CNT);
    assign pop_s         = mem_req_r & mem_ack;
    assign push_s        = want_push_s & ~full_s;
    assign reject_s      = want_push_s & full_s;
    assign load_entry_s  = (state_r == IDLE) && dl_active;
    assign flush_entry_s = (state_r == LOAD) && !dl_active;
    assign next_ptr_s    = rd_ptr_r + PTR_ONE;

    // Byte sorting, next-state selection and FIFO push request
    always_comb begin
        state_next_s = state_r;
        want_push_s  = 1'b0;
        push_addr_s  = word_addr_s;
        push_data_s  = {dl_data, 8'h00};
        hold_s       = 1'b0;
        clr_pend_s   = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                drop_s = dl_wr;
                if (dl_active) state_next_s = LOAD;
                else           state_next_s = IDLE;
            end
            LOAD: begin
                if (!dl_active) begin
                    // Bytes are only taken while the window is open; the
                    // parked low byte leaves as a zero-padded word.
                    state_next_s = FLUSH;
                    drop_s       = dl_wr;
                    want_push_s  = pend_valid_r;
                    push_addr_s  = pend_addr_r;
                    push_data_s  = {8'h00, pend_data_r};
                end else if (dl_wr && in_range_s) begin
                    if (dl_addr[0]) begin
                        want_push_s = 1'b1;
                        if (pend_valid_r && (pend_addr_r == word_addr_s)) begin
                            push_data_s = {dl_data, pend_data_r};
                            clr_pend_s  = 1'b1;
                        end else begin
                            push_data_s = {dl_data, 8'h00};
                        end
                    end else begin
                        // A parked byte of another word is evicted while the new one parks
                        hold_s = 1'b1;
                        if (pend_valid_r && (pend_addr_r != word_addr_s)) begin
                            want_push_s = 1'b1;
                            push_addr_s = pend_addr_r;
                            push_data_s = {8'h00, pend_data_r};
                        end else begin
                            want_push_s = 1'b0;
                        end
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            FLUSH: begin
                drop_s = dl_wr;
                if ((count_r == {CW{1'b0}}) && !mem_req_r) state_next_s = DONE;
                else                                        state_next_s = FLUSH;
            end
            DONE: begin
                drop_s       = dl_wr;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state, done pulse and end-of-download signature verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            done_r   <= 1'b0;
            sig_ok_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            if (load_entry_s)                                   sig_ok_r <= 1'b0;
            else if ((state_r == FLUSH) && (state_next_s == DONE)) sig_ok_r <= &sig_flags_r;
        end
    end

    // Header flags, one per byte address 0..3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_flags_r <= 4'b0000;
        end else if (load_entry_s) begin
            sig_flags_r <= 4'b0000;
        end else if ((state_r == LOAD) && dl_active && dl_wr && (dl_addr < 25'd4)) begin
            sig_flags_r[dl_addr[1:0]] <= (dl_data == sig_byte(dl_addr[1:0]));
        end
    end

    // Parked even byte; a refused push leaves it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= 24'h000000;
            pend_data_r  <= 8'h00;
        end else if (load_entry_s || flush_entry_s) begin
            pend_valid_r <= 1'b0;
        end else if (reject_s) begin
            pend_valid_r <= pend_valid_r;
        end else if (hold_s) begin
            pend_valid_r <= 1'b1;
            pend_addr_r  <= word_addr_s;
            pend_data_r  <= dl_data;
        end else if (clr_pend_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Sticky drop indicator, rearmed at each download start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    overflow_r <= 1'b0;
        else if (load_entry_s)      overflow_r <= 1'b0;
        else if (drop_s | reject_s) overflow_r <= 1'b1;
    end

    // Word storage; occupancy is tracked by count_r so contents need no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= push_addr_s;
            fifo_data_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers (wrap modulo DEPTH) and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Memory port: presents a copy of the FIFO head; the entry leaves on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 24'h000000;
            mem_data_r <= 16'h0000;
        end else if (!mem_req_r) begin
            if (count_r != {CW{1'b0}}) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= fifo_addr_r[rd_ptr_r];
                mem_data_r <= fifo_data_r[rd_ptr_r];
            end
        end else if (mem_ack) begin
            if (count_r >= CNT_TWO) begin
                mem_addr_r <= fifo_addr_r[next_ptr_s];
                mem_data_r <= fifo_data_r[next_ptr_s];
            end else if (push_s) begin
                // Last entry leaves as a new one arrives: forward it directly
                mem_addr_r <= push_addr_s;
                mem_data_r <= push_data_s;
            end else begin
                mem_req_r <= 1'b0;
            end
        end
    end

    assign dl_wait  = (count_r >= WAIT_CNT) || (state_r == FLUSH) || (state_r == DONE);
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign mem_data = mem_data_r;
    assign done     = done_r;
    assign sig_ok   = sig_ok_r;
    assign overflow = overflow_r;
endmodule

// File: tb/tb_gng_rom_packer.sv
// Testbench for gng_rom_packer: directed tables, hand-written corner
// sequences and randomized downloads compared with a byte-pairing model.
module tb_gng_rom_packer;
    localparam int          DEPTH = 4;
    localparam logic [24:0] LIMIT = 25'h0C0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait, mem_req, mem_ack, done, sig_ok, overflow;
    logic [23:0] mem_addr;
    logic [15:0] mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gng_rom_packer #(.DEPTH(DEPTH), .LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .done(done), .sig_ok(sig_ok), .overflow(overflow)
    );

    typedef struct packed { logic [23:0] addr; logic [15:0] data; } word_t;
    typedef struct {
        logic [24:0] addr; logic [7:0] data;
        bit push; logic [23:0] waddr; logic [15:0] wdata;
    } vec_t;

    word_t       exp_q [$];
    vec_t        vecs [11];
    logic [7:0]  sig_tab [4];
    bit          m_pv;
    logic [23:0] m_pa;
    logic [7:0]  m_pd;
    bit          m_flag [4];
    int          ack_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: byte pairing rules ----------------
    task automatic model_start();
        m_pv = 1'b0;
        for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        logic [23:0] w;
        w = a[24:1];
        if (a < LIMIT) begin
            if (a < 25'd4) m_flag[a[1:0]] = (d == sig_tab[a[1:0]]);
            if (a[0]) begin
                if (m_pv && m_pa == w) begin
                    exp_q.push_back({w, d, m_pd});
                    m_pv = 1'b0;
                end else begin
                    exp_q.push_back({w, d, 8'h00});
                end
            end else begin
                if (m_pv && m_pa != w) exp_q.push_back({m_pa, 8'h00, m_pd});
                m_pv = 1'b1;
                m_pa = w;
                m_pd = d;
            end
        end
    endtask

    task automatic model_end();
        if (m_pv) exp_q.push_back({m_pa, 8'h00, m_pd});
        m_pv = 1'b0;
    endtask

    // ---------------- memory side: ack driver and monitor ----------------
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'b1;
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic        prev_hold = 1'b0;
    logic [23:0] prev_addr = 24'h0;
    logic [15:0] prev_data = 16'h0;
    logic [23:0] last_addr = 24'h0;
    logic [15:0] last_data = 16'h0;
    int          done_cnt = 0;
    int          req_seen = 0;
    int          hs_cnt = 0;
    word_t       mon_w;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_req", mem_req, 1);
                    chk("hold_addr", mem_addr, prev_addr);
                    chk("hold_data", mem_data, prev_data);
                end
                if (mem_req && mem_ack) begin
                    chk("word_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        mon_w = exp_q.pop_front();
                        chk("word_addr", mem_addr, mon_w.addr);
                        chk("word_data", mem_data, mon_w.data);
                    end
                    last_addr = mem_addr;
                    last_data = mem_data;
                    hs_cnt++;
                end
                prev_hold = mem_req && !mem_ack;
                prev_addr = mem_addr;
                prev_data = mem_data;
                if (done)    done_cnt++;
                if (mem_req) req_seen++;
            end
        end
    end

    // ---------------- download-side helpers ----------------
    task automatic send_raw(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit use_model);
        int n;
        n = 0;
        while (dl_wait && n < 500) begin
            tick();
            n++;
        end
        chk("dl_wait_release", dl_wait, 0);
        if (use_model) model_byte(a, d);
        send_raw(a, d);
    endtask

    task automatic start_dl();
        model_start();
        dl_active = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        tick();
        model_end();
        chk("wait_in_flush", dl_wait, 1);
    endtask

    task automatic wait_done(input bit exp_ovf);
        int start;
        int n;
        bit exp_sig;
        start   = done_cnt;
        n       = 0;
        exp_sig = m_flag[0] & m_flag[1] & m_flag[2] & m_flag[3];
        while (done_cnt == start && n < 2000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt != start), 1);
        chk("sig_ok", sig_ok, exp_sig);
        chk("overflow", overflow, exp_ovf);
        chk("drained", 32'(exp_q.size()), 0);
        repeat (3) tick();
        chk("done_once", done_cnt - start, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sig_ok"}, sig_ok, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_dl_wait"}, dl_wait, 0);
    endtask

    task automatic sig_download();
        int hs0;
        hs0 = hs_cnt;
        start_dl();
        send_byte(25'd0, 8'h10, 1'b1);
        send_byte(25'd1, 8'h83, 1'b1);
        send_byte(25'd2, 8'h00, 1'b1);
        send_byte(25'd3, 8'h80, 1'b1);
        end_dl();
        wait_done(1'b0);
        chk("sig_words", hs_cnt - hs0, 2);
        chk("sig_last_addr", last_addr, 24'h000001);
        chk("sig_last_data", last_data, 16'h8000);
        chk("sig_ok_const", sig_ok, 1);
    endtask

    task automatic random_download(input int nbytes);
        logic [24:0] cur;
        logic [24:0] a;
        logic [7:0]  d;
        int          kind;
        cur = 25'd0;
        start_dl();
        for (int i = 0; i < nbytes; i++) begin
            kind = $urandom_range(0, 9);
            d    = 8'($urandom);
            if (kind <= 5) begin
                a   = cur;
                cur = cur + 25'd1;
            end else if (kind == 6) begin
                a   = 25'($urandom_range(0, 63));
                cur = a + 25'd1;
            end else if (kind == 7) begin
                a = LIMIT + 25'($urandom_range(0, 1000));
            end else if (kind == 8) begin
                a = 25'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) d = sig_tab[a[1:0]];
                cur = a + 25'd1;
            end else begin
                a   = LIMIT - 25'd2 + 25'($urandom_range(0, 3));
                cur = 25'($urandom_range(0, 15));
            end
            send_byte(a, d, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        end_dl();
        wait_done(1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        sig_tab[0] = 8'h10; sig_tab[1] = 8'h83; sig_tab[2] = 8'h00; sig_tab[3] = 8'h80;
        vecs[0]  = '{25'h0000011, 8'hAB, 1'b1, 24'h000008, 16'hAB00};
        vecs[1]  = '{25'h0000020, 8'h5C, 1'b0, 24'h000000, 16'h0000};
        vecs[2]  = '{25'h0000030, 8'h66, 1'b1, 24'h000010, 16'h005C};
        vecs[3]  = '{25'h0000031, 8'h77, 1'b1, 24'h000018, 16'h7766};
        vecs[4]  = '{25'h00C0000, 8'h99, 1'b0, 24'h000000, 16'h0000};
        vecs[5]  = '{25'h00BFFFF, 8'h42, 1'b1, 24'h05FFFF, 16'h4200};
        vecs[6]  = '{25'h0000040, 8'h01, 1'b0, 24'h000000, 16'h0000};
        vecs[7]  = '{25'h0000043, 8'h02, 1'b1, 24'h000021, 16'h0200};
        vecs[8]  = '{25'h0000041, 8'h03, 1'b1, 24'h000020, 16'h0301};
        vecs[9]  = '{25'h1FFFFFF, 8'h5A, 1'b0, 24'h000000, 16'h0000};
        vecs[10] = '{25'h00BFFFE, 8'hEE, 1'b0, 24'h000000, 16'h0000};

        rst = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'h00;
        model_start();
        #3;
        check_reset("por");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Header download with ack always high
        ack_mode = 1;
        sig_download();

        // Pairing table: eviction, unmatched odd, limit filter, final flush
        start_dl();
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].push) exp_q.push_back({vecs[i].waddr, vecs[i].wdata});
            send_byte(vecs[i].addr, vecs[i].data, 1'b0);
        end
        end_dl();
        exp_q.push_back({24'h05FFFF, 16'h00EE});
        wait_done(1'b0);
        chk("tbl_last_addr", last_addr, 24'h05FFFF);
        chk("tbl_last_data", last_data, 16'h00EE);

        // Six bytes with ack held low: back-pressure and a frozen head
        ack_mode = 0;
        start_dl();
        for (int i = 0; i < 6; i++) begin
            model_byte(25'(i), 8'hA0 + 8'(i));
            send_raw(25'(i), 8'hA0 + 8'(i));
            if (i == 1) chk("req_not_yet", mem_req, 0);
            if (i == 2) begin
                chk("req_next_cycle", mem_req, 1);
                chk("req_first_addr", mem_addr, 24'h000000);
            end
            if (i == 4) chk("wait_low_two", dl_wait, 0);
        end
        chk("wait_high_three", dl_wait, 1);
        repeat (3) begin
            tick();
            chk("stall_addr", mem_addr, 24'h000000);
            chk("stall_data", mem_data, 16'hA1A0);
        end
        ack_mode = 1;
        end_dl();
        wait_done(1'b0);

        // Five bytes: odd count leaves a half word for the flush
        start_dl();
        for (int i = 0; i < 5; i++) send_byte(25'(i), 8'h30 + 8'(i), 1'b1);
        end_dl();
        wait_done(1'b0);
        chk("flush_addr", last_addr, 24'h000002);
        chk("flush_data", last_data, 16'h0034);

        // Byte at LIMIT produces no request
        start_dl();
        base = req_seen;
        send_byte(LIMIT, 8'h55, 1'b1);
        repeat (6) tick();
        chk("limit_no_req", req_seen - base, 0);
        end_dl();
        wait_done(1'b0);

        // Write into a full FIFO sets overflow; next start clears it
        ack_mode = 0;
        start_dl();
        for (int i = 0; i < 9; i++) begin
            model_byte(25'(i), 8'h40 + 8'(i));
            send_raw(25'(i), 8'h40 + 8'(i));
        end
        chk("ovf_before", overflow, 0);
        send_raw(25'd9, 8'h49);
        chk("ovf_set", overflow, 1);
        chk("ovf_wait", dl_wait, 1);
        ack_mode = 1;
        repeat (3) tick();
        end_dl();
        wait_done(1'b1);
        start_dl();
        chk("ovf_cleared", overflow, 0);
        end_dl();
        wait_done(1'b0);

        // Reset in the middle of a pending handshake
        ack_mode = 0;
        start_dl();
        send_byte(25'd0, 8'h11, 1'b1);
        send_byte(25'd1, 8'h22, 1'b1);
        tick();
        chk("rst_pre_req", mem_req, 1);
        #2 rst = 1'b1;
        #1 check_reset("async");
        exp_q.delete();
        model_start();
        dl_active = 1'b0;
        ack_mode  = 1;
        tick();
        check_reset("held");
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_after_rst", mem_req, 0);
        sig_download();

        // Randomized downloads with random ack
        ack_mode = 2;
        for (int r = 0; r < 4; r++) random_download(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
